mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/arb_pick.sv | 28 ++
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    localparam int unsigned BE_W = 4;

endpackage

// File: rtl/arb_pick.sv
// Grant selection between fetch and data requests.
// With MEM_ARB_RR_EN the caller feeds a last-served pointer; otherwise the
// pointer is tied to "IF last", which makes DM win every contention.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic dm_req,
    input  logic last_dm,
    output logic grant_valid,
    output logic grant_dm
);

    owner_t pick;

    // On contention the requester not served last wins.
    always_comb begin
        grant_valid = if_req | dm_req;
        pick        = OWN_DM;
        if (if_req && dm_req) begin
            pick = last_dm ? OWN_IF : OWN_DM;
        end else if (if_req) begin
            pick = OWN_IF;
        end
        grant_dm = (pick == OWN_DM);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// One access at a time: IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> DONE.
// Optional macro MEM_ARB_RR_EN enables round-robin arbitration; without it
// DM has fixed priority over IF.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [BE_W-1:0]   dm_be,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [BE_W-1:0]   mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    owner_t            owner_q;
    logic              we_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [BE_W-1:0]   mem_be_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              if_ack_q;
    logic              dm_ack_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;

    logic grant_valid;
    logic grant_dm;
    logic last_dm;

`ifdef MEM_ARB_RR_EN
    owner_t last_q;

    // Last-served pointer, updated on every grant taken in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= OWN_IF;
        end else if (state_q == IDLE && grant_valid) begin
            last_q <= grant_dm ? OWN_DM : OWN_IF;
        end
    end

    assign last_dm = (last_q == OWN_DM);
`else
    assign last_dm = 1'b0;
`endif

    arb_pick u_pick (
        .if_req      (if_req),
        .dm_req      (dm_req),
        .last_dm     (last_dm),
        .grant_valid (grant_valid),
        .grant_dm    (grant_dm)
    );

    // Access sequencer with registered memory strobes, acks and read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= OWN_IF;
            we_q        <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        state_q  <= ISSUE;
                        mem_en_q <= 1'b1;
                        if (grant_dm) begin
                            owner_q     <= OWN_DM;
                            we_q        <= dm_we;
                            mem_we_q    <= dm_we;
                            mem_be_q    <= dm_be;
                            mem_addr_q  <= dm_addr;
                            mem_wdata_q <= dm_wdata;
                        end else begin
                            owner_q     <= OWN_IF;
                            we_q        <= 1'b0;
                            mem_we_q    <= 1'b0;
                            mem_be_q    <= '1;
                            mem_addr_q  <= if_addr;
                            mem_wdata_q <= '0;
                        end
                    end
                end
                ISSUE: begin
                    state_q     <= WAIT;
                    cnt_q       <= CNT_W'(MEM_LAT - 1);
                    mem_en_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_be_q    <= '0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                        if (owner_q == OWN_DM) begin
                            dm_ack_q <= 1'b1;
                            if (!we_q) begin
                                dm_rdata_q <= mem_rdata;
                            end
                        end else begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= mem_rdata;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_stall  = if_req & ~if_ack_q;
    assign dm_stall  = dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (MEM_LAT = 2).
module tb_mem_port_arbiter;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        dm_stall;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .if_stall  (if_stall),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_be     (dm_be),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata),
        .dm_stall  (dm_stall),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        dm;
        int unsigned cyc;
        logic [31:0] data;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic        dm;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return a ^ 32'h3C01_3000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: valid data only in the cycle MEM_LAT after the strobe.
    logic        iss_valid = 1'b0;
    int unsigned iss_cyc   = 0;
    logic [31:0] iss_addr  = '0;

    always @(negedge clk) begin
        if (mem_en) begin
            iss_valid = 1'b1;
            iss_cyc   = cyc;
            iss_addr  = mem_addr;
        end
    end

    always @(posedge clk) begin
        #1;
        if (iss_valid && cyc == iss_cyc + LAT) mem_rdata = rd_model(iss_addr);
        else mem_rdata = 32'hDEAD_BEEF;
    end

    // Scoreboard: every ack pops the oldest expectation.
    always @(negedge clk) begin
        if (if_ack && dm_ack) chk("dual_ack", {30'd0, if_ack, dm_ack}, 32'd1);
        if (if_ack || dm_ack) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {30'd0, if_ack, dm_ack}, 32'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("ack_owner", {31'd0, dm_ack}, {31'd0, e.dm});
                chk("ack_cycle", cyc, e.cyc);
                chk("ack_rdata", dm_ack ? dm_rdata : if_rdata, e.data);
            end
        end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
            sb_t e;
            e = sb.pop_front();
            chk("ack_missing", cyc, e.cyc);
        end
    end

    task automatic do_reset();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic run_single(input vec_t v);
        int unsigned t0;
        logic got;
        tick();
        t0 = cyc;
        if (v.dm) begin
            dm_req = 1'b1; dm_we = v.we; dm_be = v.be; dm_addr = v.addr; dm_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        sb.push_back('{dm: v.dm, cyc: t0 + LAT + 2, data: v.exp_rdata});
        @(negedge clk);
        chk("req_cycle_mem_en", {31'd0, mem_en}, 32'd0);
        chk("req_cycle_stall", {31'd0, v.dm ? dm_stall : if_stall}, 32'd1);
        tick();
        @(negedge clk);
        chk("issue_mem_en", {31'd0, mem_en}, 32'd1);
        chk("issue_mem_addr", mem_addr, v.addr);
        chk("issue_mem_we", {31'd0, mem_we}, {31'd0, v.dm & v.we});
        if (v.dm) begin
            chk("issue_mem_be", {28'd0, mem_be}, {28'd0, v.be});
            if (v.we) chk("issue_mem_wdata", mem_wdata, v.wdata);
        end
        got = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            @(negedge clk);
            if (mem_en) chk("wait_mem_en", {31'd0, mem_en}, 32'd0);
            if (v.dm ? dm_ack : if_ack) begin
                got = 1'b1;
                chk("ack_cycle_stall", {31'd0, v.dm ? dm_stall : if_stall}, 32'd0);
                break;
            end
        end
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
        tick();
        if_req = 1'b0;
        dm_req = 1'b0;
    endtask

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned t0;
        vecs[0] = '{dm: 1'b0, we: 1'b0, be: 4'h0, addr: 32'h0000_3000, wdata: 32'h0, exp_rdata: 32'h3C01_0000};
        vecs[1] = '{dm: 1'b1, we: 1'b1, be: 4'b0011, addr: 32'h0000_0010, wdata: 32'h1234_5678, exp_rdata: 32'h0};
        vecs[2] = '{dm: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h0000_0020, wdata: 32'h0, exp_rdata: 32'h3C01_3020};
        vecs[3] = '{dm: 1'b1, we: 1'b1, be: 4'b1100, addr: 32'h0000_0024, wdata: 32'hA5A5_0F0F, exp_rdata: 32'h3C01_3020};
        vecs[4] = '{dm: 1'b0, we: 1'b0, be: 4'h0, addr: 32'h0000_0004, wdata: 32'h0, exp_rdata: 32'h3C01_3004};

        reset = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_be = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_acks", {30'd0, if_ack, dm_ack}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        tick();
        reset = 1'b0;

        // Single transactions from the vector table.
        for (int i = 0; i < 5; i++) run_single(vecs[i]);

        // Both raised together: DM first, IF right after.
        do_reset();
        tick();
        t0 = cyc;
        if_req = 1'b1; if_addr = 32'h0000_0100;
        dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h0000_0200;
        sb.push_back('{dm: 1'b1, cyc: t0 + 4, data: rd_model(32'h0000_0200)});
        sb.push_back('{dm: 1'b0, cyc: t0 + 9, data: rd_model(32'h0000_0100)});
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) tick();
            if (k == 5) dm_req = 1'b0;
            if (k == 10) if_req = 1'b0;
            @(negedge clk);
            chk("both_if_stall", {31'd0, if_stall}, {31'd0, k <= 8});
            chk("both_dm_stall", {31'd0, dm_stall}, {31'd0, k <= 3});
        end

        // Both held for three grants.
        do_reset();
        tick();
        t0 = cyc;
        if_req = 1'b1; if_addr = 32'h0000_0300;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0400;
        sb.push_back('{dm: 1'b1, cyc: t0 + 4, data: rd_model(32'h0000_0400)});
`ifdef MEM_ARB_RR_EN
        sb.push_back('{dm: 1'b0, cyc: t0 + 9, data: rd_model(32'h0000_0300)});
`else
        sb.push_back('{dm: 1'b1, cyc: t0 + 9, data: rd_model(32'h0000_0400)});
`endif
        sb.push_back('{dm: 1'b1, cyc: t0 + 14, data: rd_model(32'h0000_0400)});
        for (int k = 1; k <= 15; k++) tick();
        if_req = 1'b0;
        dm_req = 1'b0;
        repeat (5) tick();

        // Reset during ISSUE abandons the access.
        tick();
        if_req = 1'b1; if_addr = 32'h0000_3000;
        tick();
        reset = 1'b1;
        if_req = 1'b0;
        @(negedge clk);
        chk("abort_issue_mem_en", {31'd0, mem_en}, 32'd1);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("abort_mem_en", {31'd0, mem_en}, 32'd0);
        chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
        chk("abort_mem_be", {28'd0, mem_be}, 32'd0);
        chk("abort_mem_addr", mem_addr, 32'd0);
        chk("abort_mem_wdata", mem_wdata, 32'd0);
        chk("abort_acks", {30'd0, if_ack, dm_ack}, 32'd0);
        chk("abort_if_rdata", if_rdata, 32'd0);
        chk("abort_dm_rdata", dm_rdata, 32'd0);
        repeat (6) tick();
        run_single(vecs[0]);

        // Idle bus.
        for (int k = 0; k < 10; k++) begin
            tick();
            @(negedge clk);
            chk("idle_mem_en", {31'd0, mem_en}, 32'd0);
            chk("idle_acks", {30'd0, if_ack, dm_ack}, 32'd0);
        end

        repeat (3) tick();
        chk("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
